// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning path.
//   key_state_e   : debounce FSM encoding (idle, press filter, held, release filter)
//   KEY_PRESSED   : pin level of a pressed key (board key is active-low)
//   CNT_20MS_50M  : default filter threshold minus one, 20 ms at 50 MHz
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_FILT = 2'd1,
    ST_DOWN       = 2'd2,
    ST_REL_FILT   = 2'd3
  } key_state_e;

  localparam logic        KEY_PRESSED  = 1'b0;
  localparam int unsigned CNT_20MS_50M = 999_999;

endpackage : key_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
//   sys_clock : destination clock
//   sys_rst_n : asynchronous active-low reset, both stages load RST_VAL
//   i_d       : asynchronous input bus (bits synchronised independently)
//   o_q       : synchronised output, i_d delayed by two edges
module sync_2ff #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          RST_VAL = 1'b1
) (
  input  logic             sys_clock,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_meta <= {WIDTH{RST_VAL}};
      r_sync <= {WIDTH{RST_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/key_filter.sv
// Push-button conditioner: synchronises the raw active-low key, debounces it
// and produces a clean level plus single-cycle press/release flags.
//   sys_clock   : system clock
//   sys_rst_n   : asynchronous active-low reset
//   key_in      : raw key pin, 0 = pressed
//   key_flag    : one-cycle pulse on a confirmed press
//   key_release : one-cycle pulse on a confirmed release
//   key_state   : debounced level, 1 = pressed
module key_filter
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_20MS_50M
) (
  input  logic sys_clock,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_state
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  // The sample that moves the FSM out of a stable state is the first of the
  // CNT_MAX+1 required samples, so the filter state itself sees CNT_MAX more.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             w_key_sync;
  logic             w_key_down;
  key_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_flag;
  logic             r_key_release;
  logic             r_key_state;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .sys_clock (sys_clock),
    .sys_rst_n (sys_rst_n),
    .i_d       (key_in),
    .o_q       (w_key_sync)
  );

  assign w_key_down = (w_key_sync == KEY_PRESSED);

  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_key_flag    <= 1'b0;
      r_key_release <= 1'b0;
      r_key_state   <= 1'b0;
    end else begin
      // Flags are pulses: cleared every cycle unless a filter completes.
      r_key_flag    <= 1'b0;
      r_key_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_key_down) begin
            r_state <= ST_PRESS_FILT;
          end
        end
        ST_PRESS_FILT: begin
          if (!w_key_down) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DOWN;
            r_cnt       <= '0;
            r_key_flag  <= 1'b1;
            r_key_state <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          r_cnt <= '0;
          if (!w_key_down) begin
            r_state <= ST_REL_FILT;
          end
        end
        ST_REL_FILT: begin
          if (w_key_down) begin
            r_state <= ST_DOWN;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_key_release <= 1'b1;
            r_key_state   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign key_flag    = r_key_flag;
  assign key_release = r_key_release;
  assign key_state   = r_key_state;

endmodule : key_filter

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX = 4 (press confirmed at edge 6).
module tb_key_filter;
  import key_pkg::*;

  localparam int unsigned CM  = 4;
  localparam int          LAT = CM + 2;

  logic sys_clock = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b1;
  logic key_flag;
  logic key_release;
  logic key_state;

  int n_checks = 0;
  int n_fail   = 0;

  key_filter #(
    .CNT_MAX (CM)
  ) dut (
    .sys_clock   (sys_clock),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .key_release (key_release),
    .key_state   (key_state)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic chk_outs(input string tag, input logic f, input logic r, input logic s);
    chk({tag, ".flag"}, 32'(key_flag), 32'(f));
    chk({tag, ".rel"}, 32'(key_release), 32'(r));
    chk({tag, ".state"}, 32'(key_state), 32'(s));
  endtask

  initial begin
    // Reset with key released.
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    tick(3);
    chk_outs("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.fsm", 32'(dut.r_state), 32'(ST_IDLE));
    @(negedge sys_clock);
    sys_rst_n = 1'b1;
    tick(20);
    chk_outs("idle", 1'b0, 1'b0, 1'b0);
    chk("idle.fsm", 32'(dut.r_state), 32'(ST_IDLE));

    // Clean press held: flag only after edge 6, level from edge 6 on.
    key_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk_outs($sformatf("press.e%0d", k), 1'(k == LAT), 1'b0, 1'(k >= LAT));
    end

    // Clean release: pulse after edge 6 of the rising input.
    key_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk_outs($sformatf("rel.e%0d", k), 1'b0, 1'(k == LAT), 1'(k < LAT));
    end
    chk("rel.fsm", 32'(dut.r_state), 32'(ST_IDLE));

    // Press bounce: low 3, high 1, low 3, then high -> nothing.
    for (int k = 0; k < 18; k++) begin
      key_in = (k == 3 || k >= 7) ? 1'b1 : 1'b0;
      tick(1);
      chk_outs($sformatf("pbnc.e%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Single-cycle glitch in IDLE -> nothing.
    key_in = 1'b0;
    tick(1);
    key_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_outs($sformatf("iglt.e%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Get to DOWN, then release bounce: high 2 cycles then low -> no release.
    key_in = 1'b0;
    tick(10);
    chk("down.state", 32'(key_state), 32'd1);
    chk("down.fsm", 32'(dut.r_state), 32'(ST_DOWN));
    for (int k = 0; k < 14; k++) begin
      key_in = (k < 2) ? 1'b1 : 1'b0;
      tick(1);
      chk_outs($sformatf("rbnc.e%0d", k), 1'b0, 1'b0, 1'b1);
    end

    // Release fully and let it settle back to IDLE.
    key_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk_outs($sformatf("rel2.e%0d", k), 1'b0, 1'(k == LAT), 1'(k < LAT));
    end

    // Reset mid-filter, key held through reset.
    key_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk_outs($sformatf("mid.e%0d", k), 1'b0, 1'b0, 1'b0);
    end
    chk("mid.fsm", 32'(dut.r_state), 32'(ST_PRESS_FILT));
    sys_rst_n = 1'b0;
    #1;
    chk_outs("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst.fsm", 32'(dut.r_state), 32'(ST_IDLE));
    chk("midrst.cnt", 32'(dut.r_cnt), 32'd0);
    tick(2);
    @(negedge sys_clock);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk_outs($sformatf("post.e%0d", k), 1'(k == LAT), 1'b0, 1'(k >= LAT));
    end

    key_in = 1'b1;
    tick(12);
    chk_outs("end", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_key_filter
